// File: rtl/mips_cpu_muldiv.sv
// rtl/mips_cpu_muldiv.sv - HI/LO multiply/divide unit: one-cycle multiply, iterative restoring divide
// Owns the architectural HI/LO registers; busy stalls control while a divide is running.
module mips_cpu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             write,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b110;
   localparam logic [2:0] OP_MTHI  = 3'b111;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   dvs;
   logic               qneg;
   logic               rneg;
   logic               dz;

   logic               accept;
   logic               is_signed;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH:0]     shifted;
   logic               ge;
   logic [WIDTH-1:0]   diff;
   logic [WIDTH-1:0]   q_fix;
   logic [WIDTH-1:0]   r_fix;
   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_u;

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_FIX);
   assign accept    = write & ~busy;
   assign is_signed = (op == OP_DIV);

   assign abs_a = (is_signed && a[WIDTH-1]) ? -a : a;
   assign abs_b = (is_signed && b[WIDTH-1]) ? -b : b;

   // The remainder is always below the divisor after a subtract, so W bits suffice for diff.
   assign shifted = {rem, quo[WIDTH-1]};
   assign ge      = (shifted >= {1'b0, dvs});
   assign diff    = shifted[WIDTH-1:0] - dvs;

   assign q_fix = qneg ? -quo : quo;
   assign r_fix = rneg ? -rem : rem;

   assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
   assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         qneg  <= 1'b0;
         rneg  <= 1'b0;
         dz    <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  case (op)
                     OP_MULT:  {hi, lo} <= prod_s;
                     OP_MULTU: {hi, lo} <= prod_u;
                     OP_DIV, OP_DIVU: begin
                        quo   <= abs_a;
                        dvs   <= abs_b;
                        rem   <= '0;
                        qneg  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg  <= is_signed & a[WIDTH-1];
                        dz    <= (b == '0);
                        cnt   <= CW'(WIDTH - 1);
                        state <= S_RUN;
                     end
                     OP_MTLO:  lo <= a;
                     OP_MTHI:  hi <= a;
                     default:  ;
                  endcase
               end
            end
            S_RUN: begin
               rem <= ge ? diff : shifted[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], ge};
               if (cnt == '0) state <= S_FIX;
               else           cnt   <= cnt - 1'b1;
            end
            S_FIX: begin
               // Divide by zero leaves rem = |a|, which sign-corrects back to a; only lo needs forcing.
               lo    <= dz ? '1 : q_fix;
               hi    <= r_fix;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// tb/tb_mips_cpu_muldiv.sv - directed self-checking bench for mips_cpu_muldiv
// Inputs change and outputs are sampled on the falling edge.
module tb_mips_cpu_muldiv;

   logic        clk;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  op;
   logic        write;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;

   int n_assert;
   int n_fail;
   int cyc;
   int dn;

   mips_cpu_muldiv #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .op    (op),
      .write (write),
      .hi    (hi),
      .lo    (lo),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
      @(negedge clk);
      op    = o;
      a     = va;
      b     = vb;
      write = 1'b1;
      @(negedge clk);
      write = 1'b0;
   endtask

   // Counts falling edges with busy high (bounded) and done pulses seen on them.
   task automatic wait_div(output int cycles, output int dones);
      cycles = 0;
      dones  = 0;
      while (busy && cycles < 100) begin
         if (done) dones++;
         cycles++;
         @(negedge clk);
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      reset = 1'b0;
      a     = '0;
      b     = '0;
      op    = 3'b000;
      write = 1'b0;

      #12;
      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);
      check("reset_busy", {31'b0, busy}, 32'h0);
      check("reset_done", {31'b0, done}, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      issue(3'b001, 32'hFFFFFFFD, 32'h5);
      check("mult_hi", hi, 32'hFFFFFFFF);
      check("mult_lo", lo, 32'hFFFFFFF1);
      check("mult_busy", {31'b0, busy}, 32'h0);

      issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF);
      check("multu_hi", hi, 32'hFFFFFFFE);
      check("multu_lo", lo, 32'h00000001);

      issue(3'b110, 32'h1234, 32'h0);
      check("mtlo_lo", lo, 32'h1234);
      check("mtlo_hi", hi, 32'hFFFFFFFE);

      issue(3'b000, 32'hDEAD, 32'hBEEF);
      check("nop_hi", hi, 32'hFFFFFFFE);
      check("nop_lo", lo, 32'h1234);

      issue(3'b100, 32'd100, 32'd7);
      check("divu_busy_start", {31'b0, busy}, 32'h1);
      check("divu_lo_held", lo, 32'h1234);
      wait_div(cyc, dn);
      check("divu_cycles", cyc, 33);
      check("divu_done_count", dn, 1);
      check("divu_lo", lo, 32'd14);
      check("divu_hi", hi, 32'd2);

      issue(3'b011, 32'hFFFFFFF9, 32'd2);
      wait_div(cyc, dn);
      check("div_neg_cycles", cyc, 33);
      check("div_neg_lo", lo, 32'hFFFFFFFD);
      check("div_neg_hi", hi, 32'hFFFFFFFF);

      issue(3'b011, 32'h80000000, 32'hFFFFFFFF);
      wait_div(cyc, dn);
      check("div_ovf_lo", lo, 32'h80000000);
      check("div_ovf_hi", hi, 32'h0);

      // Divide by zero with an MTHI presented on the first busy cycle.
      @(negedge clk);
      op = 3'b011; a = 32'h55; b = 32'h0; write = 1'b1;
      @(negedge clk);
      check("dz_busy_start", {31'b0, busy}, 32'h1);
      op = 3'b111; a = 32'h999; write = 1'b1;
      @(negedge clk);
      write = 1'b0;
      check("dz_mthi_ignored", hi, 32'h0);
      wait_div(cyc, dn);
      check("dz_cycles", cyc + 1, 33);
      check("dz_done_count", dn, 1);
      check("dz_lo", lo, 32'hFFFFFFFF);
      check("dz_hi", hi, 32'h55);

      issue(3'b100, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      check("abort_busy_before", {31'b0, busy}, 32'h1);
      #2;
      reset = 1'b0;
      #1;
      check("abort_hi", hi, 32'h0);
      check("abort_lo", lo, 32'h0);
      check("abort_busy", {31'b0, busy}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) dn++;
      end
      check("abort_no_done", dn, 0);
      check("abort_lo_stays", lo, 32'h0);

      issue(3'b010, 32'd3, 32'd4);
      check("post_multu_lo", lo, 32'd12);
      check("post_multu_hi", hi, 32'd0);
      check("post_multu_busy", {31'b0, busy}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_cpu_muldiv.md
Name: mips_cpu_muldiv

Overview:
Sequential multiply/divide unit that owns the architectural HI and LO registers and feeds them to the ALU's hi/lo inputs; the ALU selects them for MFHI/MFLO via the shared 3-bit op code. Multiplies complete in one cycle. Divides run as an iterative restoring divider with a busy handshake that the control unit uses to stall. MTHI/MTLO writes land here as well.

Parameters:
WIDTH, 32, operand and HI/LO width; divide latency is WIDTH+1 cycles.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
a  input  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO source
b  input  WIDTH  rt operand: multiplier or divisor
op  input  3  operation code, qualified by write
write  input  1  command strobe; op sampled on rising clk when write=1 and busy=0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  divide in progress; new commands ignored
done  output  1  one-cycle pulse when a divide writes HI/LO

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, done=0, FSM to IDLE. Any divide in flight is abandoned and its result is never written.
- Op codes with write=1:
  - 001 MULT (signed)
  - 010 MULTU
  - 011 DIV (signed)
  - 100 DIVU
  - 110 MTLO (lo<=a)
  - 111 MTHI (hi<=a)
  - 000 and 101: no effect.
- With write=0, op is ignored; 110/111 are then ALU read selects only.
- MULT/MULTU: full 2*WIDTH-bit product; {hi,lo} updated on the accepting edge. Visible the next cycle, busy stays 0.
- MTHI/MTLO: register updated on the accepting edge; the other register is unchanged.
- Divide FSM states:
  - IDLE: on accept of DIV/DIVU, latch operand magnitudes (signed: absolute values), record quotient sign (sign(a)^sign(b)) and remainder sign (sign(a)), clear the partial remainder, go to RUN; busy=1 from the next cycle.
  - RUN: one restoring shift/subtract step per cycle for WIDTH cycles; the iteration counter runs WIDTH-1 down to 0, then go to FIX.
  - FIX: apply sign correction and write lo=quotient, hi=remainder; pulse done=1 for this cycle only; busy=0 from the following cycle; go to IDLE.
- Divide latency: accept at edge E0, busy high for WIDTH+1 cycles, HI/LO written at edge E(WIDTH+1).
- hi/lo hold their previous values throughout RUN; an MFHI/MFLO issued during busy reads the old values (control stalls to avoid this).
- Sign rules: quotient truncates toward zero; remainder takes the dividend's sign. DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (no trap).
- Divide by zero (b=0, DIV or DIVU): still takes the full WIDTH+1 cycles; result lo=0xFFFFFFFF, hi=a (original a, unsigned and signed).
- write=1 while busy=1: ignored entirely, including MTHI/MTLO. busy stays high and the divide continues.
- Asserting write on the same edge that busy falls (FIX state): the command is ignored; it is accepted on the next cycle with busy=0.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> next cycle hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy stays 0.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MTLO a=0x1234 -> lo=0x1234, hi unchanged.
- DIVU a=100, b=7 -> busy high exactly 33 cycles, done pulses once, lo=14, hi=2.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- DIV a=0x55, b=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x55. MTHI issued mid-divide -> ignored, hi=0x55 at end.
- Start DIVU, drop reset at cycle 10 -> hi=lo=0 and busy=0 immediately. After release, MULTU 3*4 -> lo=12, hi=0.
